// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sample type and I2S transmitter state encoding
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_DELAY,
    TX_SHIFT,
    TX_PAD
  } i2s_tx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - synchronizer chain plus edge detector for an asynchronous codec clock
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the chain and remember the previous synchronized level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = o_level & ~prev_q;
  assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - mono I2S serializer to a codec-mastered DAC; I2S_DAC_TX_SOFTMUTE_EN enables soft-mute fading
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = audio_pkg::SAMPLE_W,
  parameter int SYNC_STAGES = 2,
  parameter int SLOT_MAX    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_mute,
  input  logic                i_aud_bclk,
  input  logic                i_aud_daclrck,
  output logic                o_aud_dacdat,
  output logic                o_sample_req,
  output logic                o_frame_err
);

  localparam int                CNT_W    = $clog2(SLOT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
  localparam logic [CNT_W-1:0] SAT_M1   = CNT_W'(SLOT_MAX - 1);

  logic bclk_level, bclk_rise, bclk_fall;
  logic lrck_level, lrck_rise, lrck_fall, lrck_edge;
  logic unused_sync;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_aud_bclk),
    .o_level (bclk_level),
    .o_rise  (bclk_rise),
    .o_fall  (bclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_aud_daclrck),
    .o_level (lrck_level),
    .o_rise  (lrck_rise),
    .o_fall  (lrck_fall)
  );

  assign lrck_edge   = lrck_rise | lrck_fall;
  assign unused_sync = ^{bclk_level, bclk_rise, lrck_level};

  i2s_tx_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] held_q, held_d;
  logic                dacdat_q, dacdat_d;
  logic                req_q, req_d;
  logic                err_q, err_d;
  logic [SAMPLE_W-1:0] latch_val;

`ifdef I2S_DAC_TX_SOFTMUTE_EN
  logic [3:0] att_q, att_d;

  // Step the attenuation one notch per frame toward full mute or full level, then scale the sample
  always_comb begin
    att_d = att_q;
    if (i_mute) begin
      if (att_q != 4'd15) att_d = att_q + 4'd1;
    end else if (att_q != 4'd0) begin
      att_d = att_q - 4'd1;
    end
    if (i_mute && (att_q == 4'd15)) latch_val = '0;
    else                            latch_val = $signed(i_sample) >>> att_d;
  end

  // Attenuation only advances at left-frame latch points
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       att_q <= 4'd0;
    else if (lrck_fall) att_q <= att_d;
  end
`else
  // Hard mute: silence replaces the sample at the next latch
  always_comb begin
    latch_val = i_mute ? '0 : i_sample;
  end
`endif

  // Frame sequencing: LRCK edges restart the frame, BCLK falls advance the bit stream
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    held_d   = held_q;
    dacdat_d = dacdat_q;
    req_d    = 1'b0;
    err_d    = err_q;
    if (lrck_edge) begin
      cnt_d   = '0;
      state_d = TX_DELAY;
      shift_d = held_q;
      if (state_q == TX_SHIFT) err_d = 1'b1;
      if (bclk_fall)           dacdat_d = 1'b0;
      if (lrck_fall) begin
        held_d  = latch_val;
        shift_d = latch_val;
        req_d   = 1'b1;
      end
    end else if (bclk_fall) begin
      case (state_q)
        TX_DELAY, TX_SHIFT: begin
          dacdat_d = shift_q[SAMPLE_W-1];
          shift_d  = {shift_q[SAMPLE_W-2:0], 1'b0};
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = (cnt_q == LAST_BIT) ? TX_PAD : TX_SHIFT;
        end
        TX_PAD: begin
          dacdat_d = 1'b0;
          if (cnt_q <= SAT_M1) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= SAT_M1) err_d = 1'b1;
        end
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      held_q   <= '0;
      dacdat_q <= 1'b0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      held_q   <= held_d;
      dacdat_q <= dacdat_d;
      req_q    <= req_d;
      err_q    <= err_d;
    end
  end

  assign o_aud_dacdat = dacdat_q;
  assign o_sample_req = req_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed bench with codec master model and I2S receiver for i2s_dac_tx
module tb_i2s_dac_tx;

  logic        i_clk;
  logic        i_rst_n;
  logic [15:0] i_sample;
  logic        i_mute;
  logic        i_aud_bclk;
  logic        i_aud_daclrck;
  logic        o_aud_dacdat;
  logic        o_sample_req;
  logic        o_frame_err;

  i2s_dac_tx dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_sample      (i_sample),
    .i_mute        (i_mute),
    .i_aud_bclk    (i_aud_bclk),
    .i_aud_daclrck (i_aud_daclrck),
    .o_aud_dacdat  (o_aud_dacdat),
    .o_sample_req  (o_sample_req),
    .o_frame_err   (o_frame_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] sample;
    logic        mute;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [7];

  int n_cmp  = 0;
  int n_fail = 0;

  logic codec_run = 1'b0;
  int   ovr_seq   = 0;
  int   ovr_len   = 32;
  int   ovr_done  = 0;
  int   half_len;

  int          rx_idx     = 99;
  logic        rx_ch      = 1'b0;
  logic        rx_valid   = 1'b0;
  logic        have_l     = 1'b0;
  logic [15:0] rx_sh      = '0;
  logic [15:0] rx_l       = '0;
  logic [15:0] last_l     = '0;
  logic [15:0] last_r     = '0;
  int          fr_cnt     = 0;
  int          delay_viol = 0;
  longint      last_fall  = 0;
  int          trans_viol = 0;
  int          req_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rx_sample();
    if (rx_idx == 0 && rx_valid && o_aud_dacdat !== 1'b0) delay_viol++;
    if (rx_idx >= 1 && rx_idx <= 16) rx_sh = {rx_sh[14:0], o_aud_dacdat};
    if (rx_idx == 16) begin
      if (!rx_ch) begin
        rx_l   = rx_sh;
        have_l = 1'b1;
      end else if (have_l) begin
        last_l = rx_l;
        last_r = rx_sh;
        fr_cnt++;
        have_l = 1'b0;
      end
    end
    rx_idx++;
  endtask

  // Codec master: BCLK = i_clk/8, LRCK toggles with a BCLK fall, receiver samples on BCLK rise
  initial begin
    i_aud_bclk    = 1'b1;
    i_aud_daclrck = 1'b0;
    wait (codec_run);
    forever begin
      half_len = 32;
      if (ovr_done != ovr_seq) begin
        half_len = ovr_len;
        ovr_done = ovr_seq;
      end
      for (int b = 0; b < half_len; b++) begin
        @(negedge i_clk);
        if (b == 0) begin
          i_aud_daclrck = ~i_aud_daclrck;
          rx_idx   = 0;
          rx_ch    = i_aud_daclrck;
          rx_valid = i_rst_n;
          if (!rx_ch) have_l = 1'b0;
        end
        i_aud_bclk = 1'b0;
        last_fall  = $time;
        repeat (4) @(negedge i_clk);
        i_aud_bclk = 1'b1;
        rx_sample();
        repeat (3) @(negedge i_clk);
      end
    end
  end

  always @(o_aud_dacdat) begin
    if (i_rst_n === 1'b1 && ($time - last_fall) > 30) trans_viol++;
  end

  always @(negedge i_clk) begin
    if (o_sample_req === 1'b1) req_cnt++;
  end

  task automatic wait_frames(input int n);
    int target;
    logic ok;
    target = fr_cnt + n;
    ok = 1'b0;
    for (int k = 0; k < n * 700; k++) begin
      @(negedge i_clk);
      if (fr_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_req();
    int start;
    logic ok;
    start = req_cnt;
    ok = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge i_clk);
      if (req_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   r0;
    int   ones;
    logic l0;
    logic seen;
    logic [15:0] exp_w;

    vecs[0] = '{16'h8001, 1'b0, 16'h8001};
    vecs[1] = '{16'h1234, 1'b0, 16'h1234};
    vecs[2] = '{16'h0000, 1'b0, 16'h0000};
    vecs[3] = '{16'hFFFF, 1'b0, 16'hFFFF};
`ifdef I2S_DAC_TX_SOFTMUTE_EN
    vecs[4] = '{16'h7FFF, 1'b1, 16'h3FFF};
`else
    vecs[4] = '{16'h7FFF, 1'b1, 16'h0000};
`endif
    vecs[5] = '{16'hA5A5, 1'b0, 16'hA5A5};
    vecs[6] = '{16'h5678, 1'b0, 16'h5678};

    i_rst_n  = 1'b0;
    i_sample = 16'h8001;
    i_mute   = 1'b0;
    repeat (5) @(negedge i_clk);
    check("rst_dacdat", 32'(o_aud_dacdat), 32'd0);
    check("rst_req", 32'(o_sample_req), 32'd0);
    check("rst_err", 32'(o_frame_err), 32'd0);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    check("idle_dacdat", 32'(o_aud_dacdat), 32'd0);
    codec_run = 1'b1;

    wait_frames(2);
    check("const_L", 32'(last_l), 32'h8001);
    check("const_R", 32'(last_r), 32'h8001);

    for (int i = 0; i < 7; i++) begin
      wait_req();
      i_sample = vecs[i].sample;
      i_mute   = vecs[i].mute;
      r0 = req_cnt;
      wait_frames(2);
      check($sformatf("vec%0d_L", i), 32'(last_l), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d_R", i), 32'(last_r), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d_req", i), 32'(req_cnt - r0), 32'd1);
    end

    wait_req();
    i_sample = 16'h1234;
    wait_req();
    repeat (100) @(negedge i_clk);
    i_sample = 16'h5678;
    wait_frames(1);
    check("midchg_L0", 32'(last_l), 32'h1234);
    check("midchg_R0", 32'(last_r), 32'h1234);
    wait_frames(1);
    check("midchg_L1", 32'(last_l), 32'h5678);
    check("midchg_R1", 32'(last_r), 32'h5678);

    i_sample = 16'h7FFF;
    wait_req();
    i_mute = 1'b1;
    wait_frames(1);
    for (int k = 1; k <= 16; k++) begin
      wait_frames(1);
`ifdef I2S_DAC_TX_SOFTMUTE_EN
      exp_w = (k < 16) ? (16'h7FFF >> k) : 16'h0000;
`else
      exp_w = 16'h0000;
`endif
      check($sformatf("mute%0d_L", k), 32'(last_l), 32'(exp_w));
      check($sformatf("mute%0d_R", k), 32'(last_r), 32'(exp_w));
    end
    i_mute = 1'b0;
`ifdef I2S_DAC_TX_SOFTMUTE_EN
    wait_frames(17);
`else
    wait_frames(2);
`endif
    check("unmute_L", 32'(last_l), 32'h7FFF);

    check("err_before_short", 32'(o_frame_err), 32'd0);
    ovr_len = 10;
    ovr_seq++;
    wait_frames(2);
    check("err_after_short", 32'(o_frame_err), 32'd1);
    check("short_recov_L", 32'(last_l), 32'h7FFF);
    check("short_recov_R", 32'(last_r), 32'h7FFF);
    wait_frames(2);
    check("err_sticky", 32'(o_frame_err), 32'd1);
    check("short_recov2_L", 32'(last_l), 32'h7FFF);

    i_sample = 16'hFFFF;
    wait_req();
    repeat (73) @(negedge i_clk);
    check("bit7_high", 32'(o_aud_dacdat), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_dacdat", 32'(o_aud_dacdat), 32'd0);
    repeat (20) @(negedge i_clk);
    check("rst_mid_err", 32'(o_frame_err), 32'd0);
    check("rst_mid_req", 32'(o_sample_req), 32'd0);
    i_rst_n = 1'b1;
    l0   = i_aud_daclrck;
    ones = 0;
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge i_clk);
      if (i_aud_daclrck != l0) begin
        seen = 1'b1;
        break;
      end
      if (o_aud_dacdat !== 1'b0) ones++;
    end
    check("edge_after_rst", 32'(seen), 32'd1);
    check("quiet_after_rst", 32'(ones), 32'd0);
    wait_frames(3);
    check("post_rst_L", 32'(last_l), 32'hFFFF);
    check("post_rst_R", 32'(last_r), 32'hFFFF);
    check("post_rst_err", 32'(o_frame_err), 32'd0);

    ovr_len = 33;
    ovr_seq++;
    wait_frames(3);
    check("err_long_half", 32'(o_frame_err), 32'd1);
    check("long_recov_L", 32'(last_l), 32'hFFFF);

    check("dacdat_timing", 32'(trans_viol), 32'd0);
    check("delay_slot_zero", 32'(delay_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
